// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: computes a - b - bin one bit per clock, LSB first.
// A start in IDLE captures the operands. The result appears on diff/bout with a one-cycle done pulse.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  // Counter must reach WIDTH itself, hence one bit beyond log2.
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic             br;
  logic [CW-1:0]    cnt;

  logic             term;
  logic             bit_d;
  logic             bit_br;

  assign term   = (cnt == CW'(WIDTH));
  assign bit_d  = a_sr[0] ^ b_sr[0] ^ br;
  assign bit_br = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & br);

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  // NOTE: next_state gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (term)  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // RUN spends WIDTH cycles shifting bits. It then spends one terminal cycle that publishes the result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      br     <= 1'b0;
      cnt    <= '0;
      diff   <= '0;
      bout   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            a_sr   <= a;
            b_sr   <= b;
            res_sr <= '0;
            br     <= bin;
            cnt    <= '0;
          end
        end
        RUN: begin
          if (term) begin
            diff <= res_sr;
            bout <= br;
          end else begin
            res_sr <= {bit_d, res_sr[WIDTH-1:1]};
            a_sr   <= {1'b0, a_sr[WIDTH-1:1]};
            b_sr   <= {1'b0, b_sr[WIDTH-1:1]};
            br     <= bit_br;
            cnt    <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor. It uses directed WIDTH=8 vectors with hand-computed results.
// It also sweeps every a, b and bin combination of a WIDTH=2 instance.
module tb_serial_subtractor;
  localparam int W   = 8;
  localparam int TMO = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n, start, bin, busy, done, bout;
  logic [W-1:0] a, b, diff;
  logic         s2, bin2, busy2, done2, bout2;
  logic [1:0]   a2, b2, diff2;

  serial_subtractor #(.WIDTH(W)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .bin(bin),
    .busy(busy), .done(done), .diff(diff), .bout(bout)
  );

  serial_subtractor #(.WIDTH(2)) u_w2 (
    .clk(clk), .rst_n(rst_n), .start(s2), .a(a2), .b(b2), .bin(bin2),
    .busy(busy2), .done(done2), .diff(diff2), .bout(bout2)
  );

  int checks = 0;
  int errors = 0;

  logic [W:0]   exp_q[$];
  logic [2:0]   exp2_q[$];
  logic [W:0]   mon_e;
  logic [2:0]   mon2_e;
  logic [W-1:0] last_diff;
  logic         last_bout;
  logic [2:0]   full2;

  // Back-to-back vectors with hand-computed {bout, diff}.
  logic [W-1:0] va [4] = '{8'h10, 8'h01, 8'hC3, 8'h7F};
  logic [W-1:0] vb [4] = '{8'h01, 8'h02, 8'h42, 8'h80};
  logic         vc [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
  logic [W:0]   ve [4] = '{9'h00F, 9'h1FE, 9'h080, 9'h1FF};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (exp_q.size() == 0) check("w8_unexpected_done", 1, 0);
      else begin
        mon_e = exp_q.pop_front();
        check("w8_diff", {24'd0, diff}, {24'd0, mon_e[W-1:0]});
        check("w8_bout", {31'd0, bout}, {31'd0, mon_e[W]});
      end
    end
    if (done2 === 1'b1) begin
      if (exp2_q.size() == 0) check("w2_unexpected_done", 1, 0);
      else begin
        mon2_e = exp2_q.pop_front();
        check("w2_diff", {30'd0, diff2}, {30'd0, mon2_e[1:0]});
        check("w2_bout", {31'd0, bout2}, {31'd0, mon2_e[2]});
      end
    end
  end

  // Called in the low clock phase; returns just after a negedge.
  task automatic run_op(input logic [W-1:0] op_a, input logic [W-1:0] op_b, input logic op_bin,
                        input logic [W-1:0] e_diff, input logic e_bout, input bit glitch,
                        input string tag);
    int cyc;
    int busy_n;
    bit seen;
    exp_q.push_back({e_bout, e_diff});
    start = 1'b1; a = op_a; b = op_b; bin = op_bin;
    @(posedge clk);
    #1 start = 1'b0;
    cyc = 0; busy_n = 0; seen = 0;
    while (!seen && cyc < TMO) begin
      @(negedge clk);
      if (busy) busy_n++;
      if (done) seen = 1;
      else begin
        if (cyc == W / 2) begin
          check({tag, "_hold_diff"}, {24'd0, diff}, {24'd0, last_diff});
          check({tag, "_hold_bout"}, {31'd0, bout}, {31'd0, last_bout});
        end
        if (glitch && cyc == 3) begin start = 1'b1; a = 8'h11; b = 8'h22; bin = 1'b1; end
        if (glitch && cyc == 4) start = 1'b0;
        @(posedge clk);
        cyc++;
      end
    end
    check({tag, "_done_seen"}, {31'd0, seen}, 1);
    check({tag, "_latency"}, cyc, W + 1);
    check({tag, "_busy_cycles"}, busy_n, W + 2);
    if (glitch) start = 1'b1;
    @(negedge clk);
    check({tag, "_done_one_cycle"}, {31'd0, done}, 0);
    check({tag, "_idle_after_done"}, {31'd0, busy}, 0);
    start = 1'b0;
    last_diff = e_diff;
    last_bout = e_bout;
  endtask

  initial begin
    int  n;
    bit  ok;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    s2 = 1'b0; a2 = '0; b2 = '0; bin2 = 1'b0;
    last_diff = '0; last_bout = 1'b0;
    #1;
    check("reset_busy", {31'd0, busy}, 0);
    check("reset_done", {31'd0, done}, 0);
    check("reset_diff", {24'd0, diff}, 0);
    check("reset_bout", {31'd0, bout}, 0);
    #20;
    @(negedge clk);
    rst_n = 1'b1;
    run_op(8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0, 0, "basic");
    run_op(8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0, 1, "ignore_start");
    run_op(8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 0, "underflow");
    run_op(8'h80, 8'h7F, 1'b1, 8'h00, 1'b0, 0, "zero_result");
    run_op(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 0, "all_ones");

    // Abort mid-RUN: outputs clear asynchronously and no done may follow.
    start = 1'b1; a = 8'h5A; b = 8'h3C; bin = 1'b0;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_busy", {31'd0, busy}, 0);
    check("abort_done", {31'd0, done}, 0);
    check("abort_diff", {24'd0, diff}, 0);
    check("abort_bout", {31'd0, bout}, 0);
    repeat (3) @(negedge clk);
    last_diff = '0; last_bout = 1'b0;
    rst_n = 1'b1;
    run_op(8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 0, "after_abort");

    // start held high: one DONE cycle and one IDLE cycle separate consecutive operations.
    start = 1'b1; a = va[0]; b = vb[0]; bin = vc[0];
    exp_q.push_back(ve[0]);
    for (int i = 0; i < 4; i++) begin
      n = 0; ok = 0;
      while (!ok && n < TMO) begin
        @(negedge clk);
        n++;
        if (done) ok = 1;
      end
      check("b2b_done_seen", {31'd0, ok}, 1);
      if (i > 0) check("b2b_spacing", n, W + 3);
      if (i < 3) begin
        a = va[i+1]; b = vb[i+1]; bin = vc[i+1];
        exp_q.push_back(ve[i+1]);
      end else start = 1'b0;
    end

    for (int x = 0; x < 4; x++) begin
      for (int y = 0; y < 4; y++) begin
        for (int c = 0; c < 2; c++) begin
          full2 = {1'b0, x[1:0]} - {1'b0, y[1:0]} - {2'b00, c[0]};
          exp2_q.push_back(full2);
          a2 = x[1:0]; b2 = y[1:0]; bin2 = c[0]; s2 = 1'b1;
          @(posedge clk);
          #1 s2 = 1'b0;
          n = 0; ok = 0;
          while (!ok && n < TMO) begin
            @(negedge clk);
            n++;
            if (done2) ok = 1;
          end
          check("w2_done_seen", {31'd0, ok}, 1);
          @(negedge clk);
        end
      end
    end

    @(negedge clk);
    check("w8_queue_empty", exp_q.size(), 0);
    check("w2_queue_empty", exp2_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
